// File: rtl/layer_out_serializer.sv
// Captures a packed vector of NN neuron outputs and streams it one word per cycle, neuron 0 first.
// Optional LAYER_SER_OVERRUN_DETECT_EN builds a sticky flag for capture requests dropped while busy.
module layer_out_serializer #(
  parameter int NN        = 30,
  parameter int dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           o_valid,
  input  logic [NN*dataWidth-1:0] x_out,
  output logic                    x_valid,
  output logic [dataWidth-1:0]    x_in,
  output logic                    busy,
  output logic                    overrun_err
);

  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IW-1:0] LAST = IW'(NN - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state;
  logic [IW-1:0]           index;
  logic [IW-1:0]           index_nxt;
  logic [NN*dataWidth-1:0] buffer;
  logic                    capture;
  logic                    unused_valid;

  // index always names the word currently presented on x_in.
  assign capture      = o_valid[0] && ((state == IDLE) || (index == LAST));
  assign index_nxt    = index + 1'b1;
  assign busy         = (state == SEND);
  assign unused_valid = &{1'b0, o_valid};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      index   <= '0;
      buffer  <= '0;
      x_valid <= 1'b0;
      x_in    <= '0;
    end else if (capture) begin
      // Word 0 comes straight from x_out so it appears the cycle after capture.
      buffer  <= x_out;
      index   <= '0;
      state   <= SEND;
      x_valid <= 1'b1;
      x_in    <= x_out[dataWidth-1:0];
    end else if (state == SEND) begin
      if (index == LAST) begin
        state   <= IDLE;
        index   <= '0;
        x_valid <= 1'b0;
      end else begin
        index <= index_nxt;
        x_in  <= buffer[index_nxt*dataWidth +: dataWidth];
      end
    end
  end

`ifdef LAYER_SER_OVERRUN_DETECT_EN
  logic ignored;
  assign ignored = o_valid[0] && (state == SEND) && (index != LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_err <= 1'b0;
    end else if (ignored) begin
      overrun_err <= 1'b1;
    end
  end
`else
  assign overrun_err = 1'b0;
`endif

endmodule

// File: tb/tb_layer_out_serializer.sv
// Bench for layer_out_serializer (NN=4, dataWidth=16) against a queue-based model of the word stream.
module tb_layer_out_serializer;
  localparam int NN = 4;
  localparam int DW = 16;
`ifdef LAYER_SER_OVERRUN_DETECT_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NN-1:0]    o_valid = '0;
  logic [NN*DW-1:0] x_out = '0;
  logic             x_valid;
  logic [DW-1:0]    x_in;
  logic             busy;
  logic             overrun_err;

  int vectors = 0;
  int errors  = 0;

  // Model: words still to be shown, front is the one on x_in now.
  logic [DW-1:0] cur_q[$];
  logic [DW-1:0] last_x = '0;
  bit            exp_ovr = 1'b0;
  logic [DW+2:0] exp_o;
  logic [DW+2:0] act_o;

  layer_out_serializer #(.NN(NN), .dataWidth(DW)) dut (
    .clk(clk), .rst(rst), .o_valid(o_valid), .x_out(x_out),
    .x_valid(x_valid), .x_in(x_in), .busy(busy), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    cur_q.delete();
    last_x  = '0;
    exp_ovr = 1'b0;
  endtask

  task automatic model_edge(input bit ov, input logic [NN*DW-1:0] xv);
    if (ov && cur_q.size() <= 1) begin
      cur_q.delete();
      for (int k = 0; k < NN; k++) cur_q.push_back(xv[k*DW +: DW]);
    end else begin
      if (ov && OVR_EN) exp_ovr = 1'b1;
      if (cur_q.size() > 0) void'(cur_q.pop_front());
    end
    if (cur_q.size() > 0) last_x = cur_q[0];
  endtask

  // Drive one cycle of inputs, advance through the rising edge, land on the falling edge.
  task automatic tick(input bit ov, input logic [NN*DW-1:0] xv);
    o_valid = {{(NN-1){1'b0}}, ov};
    x_out   = xv;
    @(posedge clk);
    model_edge(ov, xv);
    @(negedge clk);
    exp_o = {cur_q.size() > 0, cur_q.size() > 0, exp_ovr, last_x};
    act_o = {x_valid, busy, overrun_err, x_in};
  endtask

  function automatic logic [NN*DW-1:0] pack4(input logic [DW-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({x_valid, busy, overrun_err, x_in} !== '0) begin
      errors++;
      $display("FAIL reset: got v=%b b=%b o=%b x=%h want all zero", x_valid, busy, overrun_err, x_in);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    tick(1'b1, pack4(16'h0001, 16'h0002, 16'h0003, 16'h0004));
    for (int c = 0; c < 7; c++) begin
      vectors++;
      if (act_o !== exp_o) begin
        errors++;
        $display("FAIL single c%0d: got %h want %h", c, act_o, exp_o);
      end
      tick(1'b0, '0);
    end
  endtask

  task automatic test_back_to_back();
    tick(1'b1, pack4(16'h0001, 16'h0002, 16'h0003, 16'h0004));
    for (int c = 0; c < 11; c++) begin
      vectors++;
      if (act_o !== exp_o) begin
        errors++;
        $display("FAIL back_to_back c%0d: got %h want %h", c, act_o, exp_o);
      end
      // c==3 is the cycle x_in shows 0x0004.
      if (c == 3) tick(1'b1, pack4(16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3));
      else        tick(1'b0, '0);
    end
  endtask

  task automatic test_overrun();
    tick(1'b1, pack4(16'h0011, 16'h0022, 16'h0033, 16'h0044));
    for (int c = 0; c < 8; c++) begin
      vectors++;
      if (act_o !== exp_o) begin
        errors++;
        $display("FAIL overrun c%0d: got %h want %h", c, act_o, exp_o);
      end
      if (c == 1) tick(1'b1, {NN{16'hFFFF}});
      else        tick(1'b0, '0);
    end
  endtask

  task automatic test_async_reset();
    tick(1'b1, pack4(16'h0001, 16'h0002, 16'h0003, 16'h0004));
    tick(1'b0, '0);
    vectors++;
    if (act_o !== exp_o || x_in !== 16'h0002) begin
      errors++;
      $display("FAIL async_pre: got %h want %h", act_o, exp_o);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({x_valid, busy, overrun_err, x_in} !== '0) begin
      errors++;
      $display("FAIL async_reset: got v=%b b=%b o=%b x=%h want all zero", x_valid, busy, overrun_err, x_in);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick(1'b0, '0);
      vectors++;
      if (act_o !== exp_o) begin
        errors++;
        $display("FAIL async_post c%0d: got %h want %h", c, act_o, exp_o);
      end
    end
  endtask

  task automatic test_bit_exact();
    tick(1'b1, pack4(16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF));
    for (int c = 0; c < 6; c++) begin
      vectors++;
      if (act_o !== exp_o) begin
        errors++;
        $display("FAIL bit_exact c%0d: got %h want %h", c, act_o, exp_o);
      end
      tick(1'b0, '0);
    end
  endtask

  task automatic test_random();
    logic [NN*DW-1:0] v;
    bit ov;
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < NN; k++) v[k*DW +: DW] = DW'($urandom);
      ov = ($urandom_range(0, 3) == 0);
      tick(ov, v);
      vectors++;
      if (act_o !== exp_o) begin
        errors++;
        $display("FAIL random c%0d: got %h want %h", c, act_o, exp_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_async_reset();
    test_bit_exact();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
